// File: rtl/rp_dv_pack.sv
// Packs pairs of sign-extended ADC samples into 32-bit words behind a FWFT FIFO with a valid/ready output.
// Optional drop counter output drop_cnt_o is compiled in with RP_DV_PACK_DROP_CNT_EN.
module rp_dv_pack #(
   parameter int unsigned DW      = 14,
   parameter int unsigned FIFO_AW = 3
) (
   input  logic              adc_clk_i,
   input  logic              adc_rst_i,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [DW-1:0]     adc_dat_i,
   input  logic              adc_dv_i,
   output logic [31:0]       m_dat_o,
   output logic              m_vld_o,
   input  logic              m_rdy_i,
   output logic [FIFO_AW:0]  lvl_o,
   output logic              ovf_o
`ifdef RP_DV_PACK_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt_o
`endif
);

   localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

   typedef enum logic {PH_LO, PH_HI} phase_t;

   phase_t            phase, phase_nxt;
   logic [15:0]       smp_sext;
   logic [15:0]       half;
   logic              half_ld;
   logic              wr_req;
   logic [31:0]       mem [0:(1 << FIFO_AW)-1];
   logic [FIFO_AW:0]  wr_ptr, rd_ptr;
   logic              full, rd, wr_en, drop;

   assign smp_sext = 16'($signed(adc_dat_i));

   always_comb begin
      phase_nxt = phase;
      half_ld   = 1'b0;
      wr_req    = 1'b0;
      // Disabling mid-pair abandons the stored half without flagging overflow.
      if (!en_i) begin
         phase_nxt = PH_LO;
      end else if (adc_dv_i) begin
         case (phase)
            PH_LO: begin
               half_ld   = 1'b1;
               phase_nxt = PH_HI;
            end
            PH_HI: begin
               wr_req    = 1'b1;
               phase_nxt = PH_LO;
            end
            default: phase_nxt = PH_LO;
         endcase
      end
   end

   assign lvl_o   = wr_ptr - rd_ptr;
   assign full    = (lvl_o == DEPTH);
   assign m_vld_o = (wr_ptr != rd_ptr);
   assign rd      = m_vld_o && m_rdy_i;
   // A read in the same cycle frees the slot, so a full FIFO still takes the word.
   assign wr_en   = wr_req && (!full || rd);
   assign drop    = wr_req && full && !rd;
   assign m_dat_o = m_vld_o ? mem[rd_ptr[FIFO_AW-1:0]] : '0;

   always_ff @(posedge adc_clk_i) begin
      if (!adc_rst_i && wr_en) begin
         mem[wr_ptr[FIFO_AW-1:0]] <= {smp_sext, half};
      end
   end

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         phase  <= PH_LO;
         half   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_o  <= 1'b0;
      end else begin
         phase <= phase_nxt;
         if (half_ld) begin
            half <= smp_sext;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            ovf_o <= 1'b1;
         end else if (clr_i) begin
            ovf_o <= 1'b0;
         end
      end
   end

`ifdef RP_DV_PACK_DROP_CNT_EN
   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         drop_cnt_o <= '0;
      end else if (clr_i) begin
         drop_cnt_o <= {15'd0, drop};
      end else if (drop && (drop_cnt_o != '1)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

endmodule
